// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: serialises core0/core1 L1 fills and write-backs onto one
// shared main-memory port. Write-backs win over fills; otherwise the core not
// served last wins. A per-access cycle counter ends an access that memory
// never answers, and the requester gets an ack with err set.
//
// Handshakes:
//   core side:   reqN is held (with weN/addrN/wdataN) until ackN; ackN is a
//                single-cycle pulse; rdata/err are valid in that cycle only.
//                Inputs are sampled only in IDLE.
//   memory side: mem_valid stays high with mem_we/mem_addr/mem_wdata stable
//                until mem_ready is seen high at a clock edge (or the timeout
//                expires); mem_rdata is taken in the mem_ready cycle.
module l1_mem_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [1:0]        state;
    logic              owner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic              err_pending;
    logic              last_grant;
    logic [CNT_W-1:0]  cnt;
    logic              grant_any;
    logic              grant_sel;

    // Pick the winner among the current requests (only used in IDLE).
    always_comb begin
        grant_any = req0 | req1;
        grant_sel = 1'b0;
        if (req0 && req1) begin
            if (we0 != we1) begin
                grant_sel = we1;
            end else begin
                grant_sel = ~last_grant;
            end
        end else begin
            grant_sel = req1;
        end
    end

    // Sequencer: IDLE grants and latches, ACCESS waits on memory or the
    // timeout, DONE acks the owner and records it for the round-robin.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_IDLE;
            owner       <= 1'b0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            rdata_q     <= '0;
            err_pending <= 1'b0;
            last_grant  <= 1'b1;
            cnt         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        owner     <= grant_sel;
                        lat_we    <= grant_sel ? we1 : we0;
                        lat_addr  <= grant_sel ? addr1 : addr0;
                        lat_wdata <= grant_sel ? wdata1 : wdata0;
                        cnt       <= '0;
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (mem_ready) begin
                        rdata_q     <= lat_we ? '0 : mem_rdata;
                        err_pending <= 1'b0;
                        state       <= S_DONE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        rdata_q     <= '0;
                        err_pending <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    last_grant <= owner;
                    cnt        <= '0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_valid = (state == S_ACCESS);
    assign mem_we    = lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign ack0      = (state == S_DONE) && !owner;
    assign ack1      = (state == S_DONE) && owner;
    assign err       = (state == S_DONE) && err_pending;
    assign rdata     = rdata_q;
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Bench for l1_mem_arbiter: directed scenarios followed by randomized traffic
// from both cores against a transaction-level memory/arbitration model.
module tb_l1_mem_arbiter;

  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int W       = DATA_W + 2;

  logic              clk;
  logic              resetn;
  logic              req0, we0, req1, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata;
  logic              err, busy;
  logic              mem_valid, mem_we, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [1:0]        dbg_state;

  l1_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .err(err), .busy(busy),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // expected acks: {core, err, rdata}
  logic [W-1:0] exp_q[$];
  int           ack_log[$];

  // memory behaviour knobs
  int                cfg_delay   = 0;   // <0: random per access
  bit                cfg_rdata_en = 0;
  logic [DATA_W-1:0] cfg_rdata   = '0;
  bit                cfg_noise   = 0;   // random mem_ready outside accesses
  bit                scramble    = 0;   // requesters wiggle inputs while waiting

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_core(input int core, input logic r, input logic w,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (core == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic drop_req(input int core);
    if (core == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  task automatic drive_req(input int core, input logic w,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bit got;
    int n;
    @(posedge clk); #1;
    set_core(core, 1'b1, w, a, d);
    got = 0;
    n = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      if ((core == 0) ? ack0 : ack1) begin
        got = 1;
      end else begin
        @(posedge clk); #1;
        n++;
        if (scramble && $urandom_range(0, 3) == 0)
          set_core(core, 1'b1, 1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom);
      end
    end
    check($sformatf("ack_wait_core%0d", core), 64'(got), 64'd1);
    @(posedge clk); #1;
    drop_req(core);
  endtask

  task automatic core_loop(input int core, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      drive_req(core, 1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    resetn = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // Memory responder and scoreboard monitor. The model works per
  // transaction: at each new access it decides, from the requests pending
  // at the grant edge, who should have won, how memory will answer and
  // what the requester must get back.
  logic              p_req0, p_req1, p_we0, p_we1;
  logic [ADDR_W-1:0] p_addr0, p_addr1;
  logic [DATA_W-1:0] p_wdata0, p_wdata1;
  int                mdl_last;
  bit                in_acc;
  int                acc_cycles, acc_delay;
  logic [DATA_W-1:0] acc_rd, hold_rdata;
  logic              e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata;

  initial begin
    logic [W-1:0] e;
    int           winner;
    bit           timed_out;
    mdl_last = 1; in_acc = 0; hold_rdata = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        exp_q.delete();
        in_acc = 0; mdl_last = 1; hold_rdata = '0;
        mem_ready = 1'b0;
      end else begin
        // core side
        if (ack0 || ack1) begin
          check("ack_onehot", 64'(ack0 & ack1), 64'd0);
          check("busy_done", 64'(busy), 64'd1);
          if (exp_q.size() == 0) begin
            check("unexpected_ack", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("ack_core", 64'(ack1), 64'(e[W-1]));
            check("ack_err", 64'(err), 64'(e[W-2]));
            check("ack_rdata", 64'(rdata), 64'(e[DATA_W-1:0]));
            hold_rdata = e[DATA_W-1:0];
          end
          ack_log.push_back(ack1 ? 1 : 0);
        end else begin
          check("err_idle", 64'(err), 64'd0);
          check("rdata_hold", 64'(rdata), 64'(hold_rdata));
        end
        // memory side
        if (mem_valid) begin
          if (!in_acc) begin
            check("grant_has_req", 64'(p_req0 | p_req1), 64'd1);
            if (p_req0 && p_req1)
              winner = (p_we0 != p_we1) ? (p_we1 ? 1 : 0) : (1 - mdl_last);
            else
              winner = p_req1 ? 1 : 0;
            mdl_last = winner;
            e_we    = winner ? p_we1 : p_we0;
            e_addr  = winner ? p_addr1 : p_addr0;
            e_wdata = winner ? p_wdata1 : p_wdata0;
            if (cfg_delay >= 0) acc_delay = cfg_delay;
            else acc_delay = ($urandom_range(0, 7) == 0) ? TIMEOUT + 2 : $urandom_range(0, 5);
            acc_rd = cfg_rdata_en ? cfg_rdata : $urandom;
            timed_out = (acc_delay >= TIMEOUT);
            exp_q.push_back({1'(winner), timed_out, (timed_out || e_we) ? '0 : acc_rd});
            in_acc = 1;
            acc_cycles = 0;
          end
          check("mem_we", 64'(mem_we), 64'(e_we));
          check("mem_addr", 64'(mem_addr), 64'(e_addr));
          check("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
          check("busy_access", 64'(busy), 64'd1);
          if (acc_cycles == acc_delay) begin
            mem_ready = 1'b1;
            mem_rdata = acc_rd;
          end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
          end
          acc_cycles++;
        end else begin
          if (in_acc) begin
            check("valid_cycles", 64'(acc_cycles),
                  64'((acc_delay + 1 < TIMEOUT) ? acc_delay + 1 : TIMEOUT));
            in_acc = 0;
          end
          mem_ready = cfg_noise ? 1'($urandom_range(0, 1)) : 1'b0;
          mem_rdata = $urandom;
        end
      end
      p_req0 = req0; p_we0 = we0; p_addr0 = addr0; p_wdata0 = wdata0;
      p_req1 = req1; p_we1 = we1; p_addr1 = addr1; p_wdata1 = wdata1;
    end
  end

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (mem_valid) ok = 1;
    end
  endtask

  // main sequence
  initial begin
    bit ok;
    resetn = 1'b0;
    set_core(0, 1'b0, 1'b0, '0, '0);
    set_core(1, 1'b0, 1'b0, '0, '0);
    mem_ready = 1'b0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack0", 64'(ack0), 64'd0);
    check("rst_ack1", 64'(ack1), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(posedge clk); #1 resetn = 1'b1;

    // single read
    cfg_delay = 1; cfg_rdata_en = 1; cfg_rdata = 32'hDEADBEEF;
    ack_log.delete();
    drive_req(0, 1'b0, 9'h005, 32'h0);
    check("single_ack_count", 64'(ack_log.size()), 64'd1);
    check("single_ack_core", 64'(ack_log[0]), 64'd0);

    // write-back beats fill
    cfg_delay = 2; cfg_rdata = 32'hCAFE0001;
    ack_log.delete();
    fork
      drive_req(0, 1'b0, 9'h010, 32'h0);
      drive_req(1, 1'b1, 9'h020, 32'h12345678);
    join
    check("wpri_count", 64'(ack_log.size()), 64'd2);
    check("wpri_first", 64'(ack_log[0]), 64'd1);
    check("wpri_second", 64'(ack_log[1]), 64'd0);

    // round-robin from reset
    do_reset(1);
    cfg_delay = 0; cfg_rdata_en = 0;
    ack_log.delete();
    fork
      begin drive_req(0, 1'b0, 9'h001, 0); drive_req(0, 1'b0, 9'h002, 0); end
      begin drive_req(1, 1'b0, 9'h003, 0); drive_req(1, 1'b0, 9'h004, 0); end
    join
    check("rr_count", 64'(ack_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), 64'(ack_log[i]), 64'(i % 2));

    // timeout, then a normal access
    cfg_delay = 100;
    drive_req(1, 1'b0, 9'h0F0, 0);
    cfg_delay = 0;
    drive_req(1, 1'b0, 9'h0F1, 0);

    // reset in the middle of an access
    cfg_delay = 100;
    @(posedge clk); #1 set_core(1, 1'b1, 1'b0, 9'h033, 32'h0);
    wait_valid(ok);
    check("rst_mid_valid_seen", 64'(ok), 64'd1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 resetn = 1'b0; req1 = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", 64'(mem_valid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_ack", 64'(ack0 | ack1), 64'd0);
    ack_log.delete();
    repeat (25) @(negedge clk);
    check("rst_mid_no_ack", 64'(ack_log.size()), 64'd0);
    cfg_delay = 0;
    drive_req(0, 1'b0, 9'h044, 0);
    check("rst_mid_fresh", 64'(ack_log.size()), 64'd1);

    // stability under a slow memory
    cfg_delay = 5;
    drive_req(0, 1'b1, 9'h1AB, 32'hA5A55A5A);
    drive_req(1, 1'b0, 9'h0AA, 0);

    // randomized traffic
    cfg_delay = -1; cfg_noise = 1; scramble = 1;
    fork
      core_loop(0, 40);
      core_loop(1, 40);
    join
    cfg_noise = 0;
    repeat (10) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/l1_mem_arbiter.md
Name: l1_mem_arbiter

Overview:
- Two-requester arbiter/sequencer for the shared main-memory port used by the core0 and core1 L1 caches.
- Each cache presents cache-miss fills (reads) and write-backs (writes) on its own req/ack port; the block serialises them onto a single memory handshake port.
- Arbitration: write-backs beat reads; round-robin between cores otherwise.
- A timeout counter guards against a memory that never answers.

Parameters:
ADDR_W, 9, memory word address width
DATA_W, 32, data width
TIMEOUT, 16, max cycles in ACCESS waiting for mem_ready (>=2)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
req0  in  1  core0 cache request, held until ack0
we0  in  1  core0 request is write-back (1) or fill read (0)
addr0  in  ADDR_W  core0 address
wdata0  in  DATA_W  core0 write-back data
ack0  out  1  one-cycle completion pulse to core0
req1, we1, addr1, wdata1, ack1  same as core0 set, for core1
rdata  out  DATA_W  read data, valid with ack0/ack1
err  out  1  pulses with ack when the access timed out
busy  out  1  high in every state except IDLE
mem_valid  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ready  in  1  memory completion
mem_rdata  in  DATA_W  memory read data, valid with mem_ready

Behaviour:
- Reset: all outputs go to 0 while resetn=0 at a clk edge. State=IDLE, timeout counter=0. last_grant=1, so core0 wins the first tie. Reset mid-access abandons the access with no ack.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Single req: grant that core.
  - Both req, exactly one with we=1: grant the writer.
  - Both req, same we: grant the core != last_grant.
  - On grant: latch owner, we, addr, wdata into registers; go to ACCESS.
- ACCESS:
  - mem_valid=1; mem_we, mem_addr, mem_wdata driven from the latched registers and held stable for the whole state.
  - Counter increments each cycle.
  - mem_ready=1: capture mem_rdata (capture 0 if write); go to DONE with err_pending=0.
  - Else, if counter==TIMEOUT-1: go to DONE with err_pending=1 and rdata=0.
  - mem_valid drops in the cycle after mem_ready.
- DONE:
  - ack of owner=1 for exactly one cycle; rdata and err driven.
  - last_grant<=owner; counter<=0; go to IDLE.
  - rdata holds its value until the next DONE. err is high only in DONE.
- Latency: req seen at edge N -> mem_valid high in cycle N+1. With mem_ready in that same cycle, ack is in cycle N+2. Minimum 3 cycles per access; there are no back-to-back grants without passing through IDLE.
- Requester rule: req is deasserted at the edge where ack is sampled high, so req is already low in the following IDLE cycle.
- Requester inputs are ignored outside IDLE. A req dropped mid-access does not cancel it; the ack still pulses.
- mem_ready outside ACCESS is ignored.
- A pending request is never starved: it waits at most one access of the other core.

Test Plan:
- Single read: req0=1, we0=0, addr0=0x05; mem_ready=1 with mem_rdata=0xDEADBEEF one cycle after mem_valid rises -> mem_addr=0x05, mem_we=0; ack0 pulses once with rdata=0xDEADBEEF, err=0; ack1 never asserts.
- Write priority: req0 read 0x10 and req1 write 0x20/0x12345678 in the same cycle -> core1 served first (mem_we=1, mem_wdata=0x12345678), then core0 read of 0x10.
- Round-robin: both cores hold read requests continuously for 4 accesses -> grant order core0, core1, core0, core1 after reset.
- Timeout: req1 read, mem_ready held 0 -> mem_valid high for exactly TIMEOUT=16 cycles, then ack1 with err=1, rdata=0; the next request proceeds normally.
- Reset mid-ACCESS: resetn=0 for one edge while mem_valid=1 -> mem_valid=0, busy=0, no ack; a fresh req0 afterwards completes normally.
- Stability: memory delays mem_ready 5 cycles -> mem_addr, mem_we, mem_wdata unchanged across all cycles of ACCESS; busy=1 throughout.
